// File: rtl/pwl_activation_pipe.sv
// Three-stage piecewise-linear activation: two LUT banks (sigmoid/tanh),
// base/next lookup, then interpolation over the low input bits.
module pwl_activation_pipe #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_z,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic              out_mode,
    input  logic              cfg_we,
    input  logic              cfg_bank,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data
);
    localparam int FRAC_W  = DATA_W - ADDR_W;
    localparam int ENTRIES = 1 << ADDR_W;
    localparam int PROD_W  = DATA_W + 1 + FRAC_W;
    localparam logic [ADDR_W-1:0] TOP_IDX = ADDR_W'((1 << (ADDR_W - 1)) - 1);

    logic [DATA_W-1:0] r_lut [2][ENTRIES];

    logic              r_s1_valid;
    logic              r_s1_mode;
    logic [FRAC_W-1:0] r_s1_rem;
    logic [DATA_W-1:0] r_s1_base;
    logic [DATA_W-1:0] r_s1_next;

    logic                     r_s2_valid;
    logic                     r_s2_mode;
    logic [DATA_W-1:0]        r_s2_base;
    logic signed [PROD_W-1:0] r_s2_prod;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_a;
    logic              r_out_mode;

    logic                     w_adv;
    logic [ADDR_W-1:0]        w_idx;
    logic [ADDR_W-1:0]        w_nidx;
    logic [DATA_W-1:0]        w_base;
    logic [DATA_W-1:0]        w_next;
    logic signed [DATA_W:0]   w_diff;
    logic signed [PROD_W-1:0] w_diff_x;
    logic signed [PROD_W-1:0] w_rem_x;
    logic signed [PROD_W-1:0] w_prod;

    assign w_adv    = !r_out_valid | out_ready;
    assign in_ready = w_adv & !rst;

    assign w_idx  = in_z[DATA_W-1:FRAC_W];
    assign w_nidx = w_idx + ADDR_W'(1);
    assign w_base = r_lut[in_mode][w_idx];
    // The most positive segment holds flat instead of wrapping negative.
    assign w_next = (w_idx == TOP_IDX) ? w_base : r_lut[in_mode][w_nidx];

    assign w_diff   = {r_s1_next[DATA_W-1], r_s1_next}
                    - {r_s1_base[DATA_W-1], r_s1_base};
    assign w_diff_x = {{FRAC_W{w_diff[DATA_W]}}, w_diff};
    assign w_rem_x  = {{(DATA_W + 1){1'b0}}, r_s1_rem};
    assign w_prod   = w_diff_x * w_rem_x;

    // Table writes ignore stalls; same-cycle lookups see the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    r_lut[b][e] <= '0;
                end
            end
        end else if (cfg_we) begin
            r_lut[cfg_bank][cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= 1'b0;
            r_s1_rem    <= '0;
            r_s1_base   <= '0;
            r_s1_next   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_mode   <= 1'b0;
            r_s2_base   <= '0;
            r_s2_prod   <= '0;
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_mode  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid  <= in_valid;
            r_s1_mode   <= in_mode;
            r_s1_rem    <= in_z[FRAC_W-1:0];
            r_s1_base   <= w_base;
            r_s1_next   <= w_next;
            r_s2_valid  <= r_s1_valid;
            r_s2_mode   <= r_s1_mode;
            r_s2_base   <= r_s1_base;
            r_s2_prod   <= w_prod;
            r_out_valid <= r_s2_valid;
            r_out_mode  <= r_s2_mode;
            r_out_a     <= r_s2_base + DATA_W'(r_s2_prod >>> FRAC_W);
        end
    end

    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_mode  = r_out_mode;
endmodule

// File: tb/tb_pwl_activation_pipe.sv
// Bench for pwl_activation_pipe: directed cases plus random traffic
// scored against an arithmetic model of the two activation tables.
module tb_pwl_activation_pipe;
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_z;
    logic              in_mode;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_a;
    logic              out_mode;
    logic              cfg_we;
    logic              cfg_bank;
    logic [3:0]        cfg_addr;
    logic [7:0]        cfg_data;

    pwl_activation_pipe #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_z(in_z), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_mode(out_mode),
        .cfg_we(cfg_we), .cfg_bank(cfg_bank),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int m;
    } exp_t;

    int   n_chk = 0;
    int   n_err = 0;
    int   mdl [2][16];
    exp_t q[$];
    int   cyc = 0;
    int   acc_cyc = 0;
    int   pop_cyc = 0;
    int   npops = 0;
    int   last_a = 0;
    int   last_m = 0;
    bit   prev_stall = 0;
    int   prev_a = 0;
    bit   acc;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_act(input int bank, input logic [7:0] z);
        int idx = int'(z[7:4]);
        int rem = int'(z[3:0]);
        int base, nxt, p, d;
        base = mdl[bank][idx];
        nxt  = (idx == 7) ? base : mdl[bank][(idx + 1) % 16];
        p = (nxt - base) * rem;
        d = p / 16;
        if (p < 0 && (p % 16) != 0) d--;
        return base + d;
    endfunction

    // One clock: observe at the falling edge, then step to just past the rise.
    task automatic tick(output bit accepted);
        exp_t e;
        accepted = 0;
        @(negedge clk);
        if (rst) begin
            check("rst_in_ready", int'(in_ready), 0);
            q.delete();
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 16; i++) mdl[b][i] = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_a", int'(out_a), prev_a);
                check("hold_valid", int'(out_valid), 1);
            end
            if (out_valid && !out_ready)
                check("stall_in_ready", int'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("extra_beat", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    check("out_a", int'(out_a), e.a);
                    check("out_mode", int'(out_mode), e.m);
                    last_a = int'(out_a);
                    last_m = int'(out_mode);
                    pop_cyc = cyc;
                    npops++;
                end
            end
            if (in_valid && in_ready) begin
                e.a = ref_act(int'(in_mode), in_z);
                e.m = int'(in_mode);
                q.push_back(e);
                accepted = 1;
                acc_cyc = cyc;
            end
            if (cfg_we) mdl[cfg_bank][cfg_addr] = int'($signed(cfg_data));
            prev_stall = out_valid && !out_ready;
            prev_a = int'(out_a);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit bank, input int addr, input int data);
        bit a;
        cfg_we = 1; cfg_bank = bank;
        cfg_addr = 4'(addr); cfg_data = 8'(data);
        tick(a);
        cfg_we = 0;
    endtask

    task automatic send1(input logic [7:0] z, input bit mode);
        bit a;
        int n = 0;
        in_valid = 1; in_z = z; in_mode = mode;
        a = 0;
        while (!a && n < 20) begin
            tick(a);
            n++;
        end
        if (!a) check("send_timeout", n, 0);
        in_valid = 0;
    endtask

    task automatic drain();
        bit a;
        int n = 0;
        in_valid = 0; cfg_we = 0; out_ready = 1;
        while (q.size() != 0 && n < 20) begin
            tick(a);
            n++;
        end
        tick(a);
        check("drain", q.size(), 0);
    endtask

    logic [7:0] bp_z [6] = '{8'h28, 8'h5C, 8'h7F, 8'hF8, 8'h20, 8'h13};
    bit         bp_m [6] = '{0, 1, 0, 0, 0, 1};

    initial begin
        int j, n0;
        rst = 1; in_valid = 0; in_z = 0; in_mode = 0; out_ready = 1;
        cfg_we = 0; cfg_bank = 0; cfg_addr = 0; cfg_data = 0;
        #1;
        tick(acc);
        tick(acc);
        rst = 0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_a", int'(out_a), 0);
        check("rst_out_mode", int'(out_mode), 0);
        check("post_rst_in_ready", int'(in_ready), 1);

        wr(0, 2, 40);
        wr(0, 3, 56);
        send1(8'h28, 0);
        drain();
        check("basic_a", last_a, 48);
        check("basic_mode", last_m, 0);
        check("basic_latency", pop_cyc - acc_cyc, 3);

        wr(1, 5, 100);
        wr(1, 6, 21);
        send1(8'h5C, 1);
        drain();
        check("floor_a", last_a, 40);
        check("floor_mode", last_m, 1);

        wr(0, 7, 127);
        wr(0, 8, -128);
        send1(8'h7F, 0);
        drain();
        check("hold_top", last_a, 127);
        wr(0, 15, -8);
        wr(0, 0, 0);
        send1(8'hF8, 0);
        drain();
        check("wrap_neg1", last_a, -4);

        cfg_we = 1; cfg_bank = 0; cfg_addr = 2; cfg_data = 80;
        in_valid = 1; in_z = 8'h20; in_mode = 0;
        tick(acc);
        check("coll_accept", int'(acc), 1);
        cfg_we = 0; in_valid = 0;
        drain();
        check("coll_old", last_a, 40);
        send1(8'h20, 0);
        drain();
        check("coll_new", last_a, 80);

        n0 = npops;
        j = 0;
        for (int t = 0; t < 40 && !(j == 6 && t >= 8); t++) begin
            in_valid = (j < 6);
            in_z = bp_z[j % 6];
            in_mode = bp_m[j % 6];
            out_ready = !(t >= 4 && t < 8);
            tick(acc);
            if (acc) j++;
        end
        in_valid = 0;
        drain();
        check("bp_count", npops - n0, 6);

        in_valid = 1; in_mode = 0;
        for (int i = 0; i < 3; i++) begin
            in_z = 8'(8'h28 + i);
            tick(acc);
        end
        in_valid = 0;
        rst = 1;
        cfg_we = 1; cfg_bank = 0; cfg_addr = 2; cfg_data = 99;
        tick(acc);
        rst = 0; cfg_we = 0;
        check("midrst_out_a", int'(out_a), 0);
        for (int i = 0; i < 5; i++) begin
            check("midrst_valid", int'(out_valid), 0);
            tick(acc);
        end
        send1(8'h28, 0);
        drain();
        check("cleared_lut", last_a, 0);

        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom % 4) != 0;
            in_z      = 8'($urandom);
            in_mode   = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            cfg_we    = ($urandom % 6) == 0;
            cfg_bank  = 1'($urandom);
            cfg_addr  = 4'($urandom);
            cfg_data  = 8'($urandom);
            tick(acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
